irq_ctrl: RTL

- Interrupt request controller that sits directly upstream of the RISC-V core's interrupt input.
- Inputs:
  - Debounced buttons from the debounce block.
  - Raw switches, which this block synchronises.
- Edge-detects each source, latches it as pending, and presents one prioritised request with a source ID to the core.
- The core acknowledges the request. The top level replaces its ad-hoc OR of buttons and switches with this block.

---
 rtl/irq_ctrl_pkg.sv | 32 +++
 rtl/irq_edge_det.sv | 50 +++++
 rtl/irq_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the interrupt request controller:
// FSM encoding, source indices, request-ID width and the priority helper.
package irq_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      HOLDOFF = 2'd2
   } state_t;

   localparam int ID_W    = 3;
   localparam int MAX_SRC = 1 << ID_W;

   localparam int BTN0 = 0;
   localparam int BTN1 = 1;
   localparam int BTN2 = 2;
   localparam int BTN3 = 3;
   localparam int SW0  = 4;
   localparam int SW1  = 5;
   localparam int SW2  = 6;

   // Lowest set bit wins; returns 0 when nothing is set.
   function automatic logic [ID_W-1:0] lowest_set(input logic [MAX_SRC-1:0] v);
      logic [ID_W-1:0] idx;
      idx = '0;
      for (int i = MAX_SRC - 1; i >= 0; i--) begin
         if (v[i]) idx = ID_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/irq_edge_det.sv
// Per-source edge detector: optional two-flop synchroniser, arming gate after
// reset, and rising-only or both-edge detection.
module irq_edge_det
   import irq_ctrl_pkg::*;
#(
   parameter bit SYNC       = 1'b0,
   parameter bit BOTH_EDGES = 1'b0
) (
   input  logic CLK,
   input  logic nrst,
   input  logic src,
   output logic pulse
);

   // A synchronised source stays disarmed until its synchroniser holds a real
   // sample, so a switch already on at reset release never interrupts.
   localparam int ARM_DEPTH = SYNC ? 3 : 1;

   logic                 sample;
   logic                 prev_reg;
   logic [ARM_DEPTH-1:0] arm_reg;
   logic                 armed;

   generate
      if (SYNC) begin : g_sync
         logic [1:0] sync_reg;
         always_ff @(posedge CLK or negedge nrst) begin
            if (!nrst) sync_reg <= '0;
            else       sync_reg <= {sync_reg[0], src};
         end
         assign sample = sync_reg[1];
      end else begin : g_direct
         assign sample = src;
      end
   endgenerate

   always_ff @(posedge CLK or negedge nrst) begin
      if (!nrst) begin
         arm_reg  <= '0;
         prev_reg <= 1'b0;
      end else begin
         arm_reg  <= (arm_reg << 1) | ARM_DEPTH'(1);
         prev_reg <= sample;
      end
   end

   assign armed = arm_reg[ARM_DEPTH-1];
   assign pulse = armed && (BOTH_EDGES ? (sample ^ prev_reg) : (sample & ~prev_reg));

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt request controller: latches source edges as pending and presents one
// prioritised request to the core. Optional IRQ_TIMEOUT_EN abandons unacked requests.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int NUM_BTN        = 4,
   parameter int NUM_SW         = 3,
   parameter int HOLDOFF_CYCLES = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                       CLK,
   input  logic                       nrst,
   input  logic [NUM_BTN-1:0]         btn_in,
   input  logic [NUM_SW-1:0]          switch_in,
   input  logic [NUM_BTN+NUM_SW-1:0]  int_mask,
   input  logic                       int_ack,
   output logic                       int_req,
   output logic [ID_W-1:0]            int_id,
   output logic [NUM_BTN+NUM_SW-1:0]  int_pending,
   output logic                       int_overrun
);

   localparam int NUM_SRC = NUM_BTN + NUM_SW;

   logic [NUM_SRC-1:0] edges;
   logic [NUM_SRC-1:0] clr;
   logic [NUM_SRC-1:0] pending_reg, pending_next;
   logic               overrun_reg, overrun_set;
   state_t             state_reg, state_next;
   logic [ID_W-1:0]    id_reg, id_next, winner;
   logic [15:0]        hold_reg, hold_next;
   logic               ack_take;
   logic               timeout_hit;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
         irq_edge_det #(.SYNC(1'b0), .BOTH_EDGES(1'b0)) u_det (
            .CLK   (CLK),
            .nrst  (nrst),
            .src   (btn_in[gi]),
            .pulse (edges[BTN0 + gi])
         );
      end
      for (gi = 0; gi < NUM_SW; gi++) begin : g_sw
         irq_edge_det #(.SYNC(1'b1), .BOTH_EDGES(1'b1)) u_det (
            .CLK   (CLK),
            .nrst  (nrst),
            .src   (switch_in[gi]),
            .pulse (edges[NUM_BTN + gi])
         );
      end
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_clr
         assign clr[gi] = ack_take && (id_reg == ID_W'(gi));
      end
   endgenerate

`ifdef IRQ_TIMEOUT_EN
   logic [15:0] to_reg;

   always_ff @(posedge CLK or negedge nrst) begin
      if (!nrst)                 to_reg <= '0;
      else if (state_reg == REQ) to_reg <= to_reg + 16'd1;
      else                       to_reg <= '0;
   end

   // An ack in the same cycle wins over the timeout.
   assign timeout_hit = (state_reg == REQ) && !int_ack &&
                        (to_reg == 16'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
   assign timeout_hit    = 1'b0;
`endif

   assign winner = lowest_set(MAX_SRC'(pending_reg & int_mask));

   always_comb begin
      state_next = state_reg;
      id_next    = id_reg;
      hold_next  = hold_reg;
      ack_take   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (|(pending_reg & int_mask)) begin
               id_next    = winner;
               state_next = REQ;
            end
         end
         REQ: begin
            if (int_ack) begin
               ack_take   = 1'b1;
               hold_next  = 16'(HOLDOFF_CYCLES - 1);
               state_next = HOLDOFF;
            end else if (timeout_hit) begin
               hold_next  = 16'(HOLDOFF_CYCLES - 1);
               state_next = HOLDOFF;
            end
         end
         HOLDOFF: begin
            if (hold_reg == 16'd0) state_next = IDLE;
            else                   hold_next  = hold_reg - 16'd1;
         end
         default: state_next = IDLE;
      endcase
   end

   // A fresh edge on the source being acked re-arms it without counting as overrun.
   assign pending_next = edges | (pending_reg & ~clr);
   assign overrun_set  = (|(edges & pending_reg & ~clr)) | timeout_hit;

   always_ff @(posedge CLK or negedge nrst) begin
      if (!nrst) begin
         state_reg   <= IDLE;
         id_reg      <= '0;
         hold_reg    <= '0;
         pending_reg <= '0;
         overrun_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         id_reg      <= id_next;
         hold_reg    <= hold_next;
         pending_reg <= pending_next;
         overrun_reg <= overrun_reg | overrun_set;
      end
   end

   assign int_req     = (state_reg == REQ);
   assign int_id      = id_reg;
   assign int_pending = pending_reg;
   assign int_overrun = overrun_reg;

endmodule
